// File: rtl/cfs_synch_filt_if.sv
// Bundle for cfs_synch_filt: the asynchronous input vector and the filtered outputs.
// The master side drives i and consumes the outputs; the filter itself is the slave.
interface cfs_synch_filt_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] i;
    logic [DATA_WIDTH-1:0] o;
    logic [DATA_WIDTH-1:0] o_rise;
    logic [DATA_WIDTH-1:0] o_fall;
    logic                  o_changed;

    modport master (output i, input o, o_rise, o_fall, o_changed);
    modport slave  (input i, output o, o_rise, o_fall, o_changed);
endinterface

// File: rtl/cfs_synch_filt.sv
// Per-bit multi-flop synchronizer followed by a consecutive-sample deglitch filter,
// with registered rise/fall/changed pulses aligned to the first cycle of a new output value.
module cfs_synch_filt #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    STAGES        = 2,
    parameter int                    FILTER_CYCLES = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = {DATA_WIDTH{1'b0}}
) (
    input  logic           clk,
    input  logic           reset_n,
    cfs_synch_filt_if.slave bus
);
    localparam int              CNT_W   = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES);

    generate
        if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
            $error("cfs_synch_filt: STAGES must be in 2..8");
        end
        if (FILTER_CYCLES < 0 || FILTER_CYCLES > 255) begin : g_bad_filter
            $error("cfs_synch_filt: FILTER_CYCLES must be in 0..255");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] sync_q [STAGES];
    logic [DATA_WIDTH-1:0] sync_d [STAGES];
    logic [DATA_WIDTH-1:0] s;
    logic [DATA_WIDTH-1:0] update;
    logic [DATA_WIDTH-1:0] o_q, o_d;
    logic [DATA_WIDTH-1:0] rise_q, rise_d;
    logic [DATA_WIDTH-1:0] fall_q, fall_d;
    logic                  changed_q, changed_d;

    // Pure flop chain: nothing may sit between stages or metastability settling time is lost.
    always_comb begin
        sync_d[0] = bus.i;
        for (int k = 1; k < STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    assign s = sync_q[STAGES-1];

    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             differs;

        assign differs     = (s[gi] != o_q[gi]);
        assign update[gi]  = differs && (cnt_q == CNT_MAX);

        // Any agreeing sample, or the update itself, restarts qualification from zero.
        always_comb begin
            cnt_d = '0;
            if (differs && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    always_comb begin
        o_d       = o_q ^ update;
        rise_d    = update & s;
        fall_d    = update & ~s;
        changed_d = |update;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= RESET_VALUE;
            end
            o_q       <= RESET_VALUE;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            o_q       <= o_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign bus.o         = o_q;
    assign bus.o_rise    = rise_q;
    assign bus.o_fall    = fall_q;
    assign bus.o_changed = changed_q;
endmodule

// File: tb/tb_cfs_synch_filt.sv
// Bench for cfs_synch_filt: two instances (2-stage/3-sample filter, 3-stage/unfiltered)
// checked every cycle against a sample-window model, plus directed literal expectations.
module tb_cfs_synch_filt;
    logic       clk;
    logic       reset_n;
    logic [7:0] in1, in2;
    int         n_assert = 0;
    int         n_fail   = 0;

    cfs_synch_filt_if #(.DATA_WIDTH(8)) bus1 ();
    cfs_synch_filt_if #(.DATA_WIDTH(8)) bus2 ();
    assign bus1.i = in1;
    assign bus2.i = in2;

    cfs_synch_filt #(.DATA_WIDTH(8), .STAGES(2), .FILTER_CYCLES(3), .RESET_VALUE(8'h00)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1));
    cfs_synch_filt #(.DATA_WIDTH(8), .STAGES(3), .FILTER_CYCLES(0), .RESET_VALUE(8'hFF)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model: output changes when the last FILTER_CYCLES+1 synchronized samples all disagree
    logic [7:0] ihist [2][256];
    int         ec = 0;
    logic [7:0] mo [2] = '{8'h00, 8'hFF};
    logic [7:0] mr [2] = '{8'h00, 8'h00};
    logic [7:0] mf [2] = '{8'h00, 8'h00};
    logic       mc [2] = '{1'b0, 1'b0};

    function automatic int stg_of(input int d);
        return (d == 0) ? 2 : 3;
    endfunction
    function automatic int fc_of(input int d);
        return (d == 0) ? 3 : 0;
    endfunction
    function automatic logic [7:0] rv_of(input int d);
        return (d == 0) ? 8'h00 : 8'hFF;
    endfunction

    // Synchronized sample visible after edge m: the input captured STAGES-1 edges earlier.
    function automatic logic [7:0] s_at(input int d, input int m);
        int idx;
        idx = m - stg_of(d) + 1;
        if (idx >= 1) return ihist[d][idx];
        return rv_of(d);
    endfunction

    task automatic model_step(input int d);
        logic [7:0] sv, up;
        logic       hit;
        up = '0;
        for (int b = 0; b < 8; b++) begin
            hit = 1'b1;
            for (int k = 0; k <= fc_of(d); k++) begin
                sv = s_at(d, ec - 1 - k);
                if (sv[b] == mo[d][b]) hit = 1'b0;
            end
            up[b] = hit;
        end
        mr[d] = up & ~mo[d];
        mf[d] = up & mo[d];
        mc[d] = |up;
        mo[d] = mo[d] ^ up;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                ec = 0;
                for (int d = 0; d < 2; d++) begin
                    mo[d] = rv_of(d);
                    mr[d] = '0;
                    mf[d] = '0;
                    mc[d] = 1'b0;
                end
            end else begin
                if (ec < 255) ec++;
                ihist[0][ec] = in1;
                ihist[1][ec] = in2;
                model_step(0);
                model_step(1);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("model_o1",       {24'd0, bus1.o},      {24'd0, mo[0]});
            chk("model_rise1",    {24'd0, bus1.o_rise}, {24'd0, mr[0]});
            chk("model_fall1",    {24'd0, bus1.o_fall}, {24'd0, mf[0]});
            chk("model_changed1", {31'd0, bus1.o_changed}, {31'd0, mc[0]});
            chk("model_o2",       {24'd0, bus2.o},      {24'd0, mo[1]});
            chk("model_rise2",    {24'd0, bus2.o_rise}, {24'd0, mr[1]});
            chk("model_fall2",    {24'd0, bus2.o_fall}, {24'd0, mf[1]});
            chk("model_changed2", {31'd0, bus2.o_changed}, {31'd0, mc[1]});
            chk("rise_fall_excl1", {24'd0, bus1.o_rise & bus1.o_fall}, 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset both instances, then present new inputs so the next rising edge is edge 1.
    task automatic start_test(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        #1 reset_n = 1'b0; in1 = 8'h00; in2 = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        #1 reset_n = 1'b1; in1 = a; in2 = b;
    endtask

    function automatic logic pat033(input int e);
        return (e == 1 || e == 2 || (e >= 4 && e <= 7));
    endfunction

    initial begin
        reset_n = 1'b0;
        in1     = 8'h00;
        in2     = 8'hFF;
        tick();

        // A5 held: appears at edge 6 with a single rise pulse.
        start_test(8'hA5, 8'hFF);
        for (int e = 1; e <= 9; e++) begin
            tick();
            chk("t030_o",       {24'd0, bus1.o},      (e >= 6) ? 32'hA5 : 32'h00);
            chk("t030_rise",    {24'd0, bus1.o_rise}, (e == 6) ? 32'hA5 : 32'h00);
            chk("t030_fall",    {24'd0, bus1.o_fall}, 32'h00);
            chk("t030_changed", {31'd0, bus1.o_changed}, (e == 6) ? 32'd1 : 32'd0);
        end
        #1 reset_n = 1'b0;
        #1 chk("t030_async_o", {24'd0, bus1.o}, 32'h00);

        // 3-cycle glitch on bit 0 never reaches the output.
        start_test(8'h01, 8'hFF);
        for (int e = 1; e <= 10; e++) begin
            tick();
            chk("t031_o",       {24'd0, bus1.o}, 32'h00);
            chk("t031_changed", {31'd0, bus1.o_changed}, 32'd0);
            if (e == 3) #1 in1 = 8'h00;
        end

        // Exactly 4 cycles high: rise at edge 6, fall at edge 10.
        start_test(8'h01, 8'hFF);
        for (int e = 1; e <= 12; e++) begin
            tick();
            chk("t032_o0",    {31'd0, bus1.o[0]},      (e >= 6 && e <= 9) ? 32'd1 : 32'd0);
            chk("t032_rise0", {31'd0, bus1.o_rise[0]}, (e == 6) ? 32'd1 : 32'd0);
            chk("t032_fall0", {31'd0, bus1.o_fall[0]}, (e == 10) ? 32'd1 : 32'd0);
            if (e == 4) #1 in1 = 8'h00;
        end

        // High 2, low 1, high 4: only the final run qualifies, rise at edge 9.
        start_test(8'h01, 8'hFF);
        for (int e = 1; e <= 15; e++) begin
            tick();
            chk("t033_o0",    {31'd0, bus1.o[0]},      (e >= 9 && e <= 12) ? 32'd1 : 32'd0);
            chk("t033_rise0", {31'd0, bus1.o_rise[0]}, (e == 9) ? 32'd1 : 32'd0);
            #1 in1 = {7'd0, pat033(e + 1)};
        end

        // Reset mid-qualification discards the pending change.
        start_test(8'hFF, 8'hFF);
        for (int e = 1; e <= 4; e++) tick();
        #1 reset_n = 1'b0;
        #1 chk("t034_async_o", {24'd0, bus1.o}, 32'h00);
        chk("t034_async_changed", {31'd0, bus1.o_changed}, 32'd0);
        tick();
        #1 reset_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk("t034_o",    {24'd0, bus1.o},      (e >= 6) ? 32'hFF : 32'h00);
            chk("t034_rise", {24'd0, bus1.o_rise}, (e == 6) ? 32'hFF : 32'h00);
        end
        #1 reset_n = 1'b0;
        #1 chk("t034_async_clear", {24'd0, bus1.o}, 32'h00);

        // Second instance: 3 stages, no filtering, reset value FF.
        start_test(8'h00, 8'h0F);
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk("t035_o2",       {24'd0, bus2.o},      (e >= 4) ? 32'h0F : 32'hFF);
            chk("t035_fall2",    {24'd0, bus2.o_fall}, (e == 4) ? 32'hF0 : 32'h00);
            chk("t035_rise2",    {24'd0, bus2.o_rise}, 32'h00);
            chk("t035_changed2", {31'd0, bus2.o_changed}, (e == 4) ? 32'd1 : 32'd0);
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/cfs_synch_filt.md
CFS_SYNCH_FILT -- requirements
Module: cfs_synch_filt

Interface
REQ-001 Parameter DATA_WIDTH, default 32: number of independent single-bit channels.
REQ-002 Parameter STAGES, default 2: synchronizer flop depth per bit; legal range 2..8, otherwise elaboration error.
REQ-003 Parameter FILTER_CYCLES, default 0: extra consecutive samples a new value must be held before it is accepted; legal range 0..255, otherwise elaboration error.
REQ-004 Parameter RESET_VALUE, default {DATA_WIDTH{1'b0}}: DATA_WIDTH-bit value loaded into all synchronizer stages and o at reset.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 i  input  DATA_WIDTH  asynchronous or foreign-domain inputs.
REQ-008 o  output  DATA_WIDTH  synchronized, deglitched value, registered on clk.
REQ-009 o_rise  output  DATA_WIDTH  per-bit one-cycle pulse, 1 when o[b] has just changed 0->1.
REQ-010 o_fall  output  DATA_WIDTH  per-bit one-cycle pulse, 1 when o[b] has just changed 1->0.
REQ-011 o_changed  output  1  one-cycle pulse, 1 when any bit of o has just changed.

Function
REQ-012 Each bit b SHALL pass through a chain of STAGES flops; the last stage is the synchronized sample s[b]; no logic between stages.
REQ-013 Each bit SHALL own a counter cnt[b] of width clog2(FILTER_CYCLES+1), minimum 1 bit.
REQ-014 Per edge, if s[b]==o[b]: cnt[b] <= 0, o[b] holds.
REQ-015 Per edge, if s[b]!=o[b] and cnt[b]<FILTER_CYCLES: cnt[b] <= cnt[b]+1, o[b] holds.
REQ-016 Per edge, if s[b]!=o[b] and cnt[b]==FILTER_CYCLES: o[b] <= s[b], cnt[b] <= 0 (update event).
REQ-017 Any single-cycle return of s[b] to o[b] SHALL clear cnt[b]; qualification restarts from zero.
REQ-018 Latency: a change on i[b] captured at edge 1 and held stable SHALL appear on o[b] at edge STAGES+FILTER_CYCLES+1.
REQ-019 A change on s[b] lasting fewer than FILTER_CYCLES+1 consecutive samples SHALL never reach o[b].
REQ-020 With FILTER_CYCLES=0, o SHALL equal s delayed by one clock (plain registered synchronizer).
REQ-021 o_rise[b] SHALL be registered at the update edge as (update event AND s[b]==1), else 0; o_fall[b] likewise with s[b]==0.
REQ-022 o_rise/o_fall SHALL be high exactly one cycle, coincident with the first cycle o shows the new value.
REQ-023 o_changed SHALL be registered as OR of all bits' update events; coincident with o_rise/o_fall.
REQ-024 Bits SHALL be fully independent; simultaneous updates on several bits in one cycle are all reported in the same cycle.
REQ-025 o_rise[b] and o_fall[b] SHALL never be 1 in the same cycle.

Reset
REQ-026 reset_n low SHALL immediately, without clk, set all synchronizer stages and o to RESET_VALUE, cnt to 0, o_rise/o_fall to 0, o_changed to 0.
REQ-027 reset_n asserted mid-qualification SHALL discard the pending change; no pulse is produced for it.
REQ-028 After reset_n release with i==RESET_VALUE, no pulse SHALL ever be produced until i changes.
REQ-029 Reset release SHALL be treated as synchronous to clk by the integrator; the block adds no release synchronizer.

Verification (DATA_WIDTH=8, STAGES=2, FILTER_CYCLES=3, RESET_VALUE=8'h00 unless stated)
REQ-030 Reset, then i=8'hA5 held from edge 1 -> o=8'hA5 from edge 6; o_rise=8'hA5 and o_changed=1 for that cycle only; o_fall=0 throughout.
REQ-031 i[0] high for 3 cycles then low -> o, o_rise, o_fall, o_changed stay 0.
REQ-032 i[0] high for exactly 4 cycles from edge 1 -> o[0] rises at edge 6 with o_rise[0] pulse, falls at edge 10 with o_fall[0] pulse.
REQ-033 i[0] high 2 cycles, low 1, high 4 -> only the final 4-cycle run qualifies; single o_rise[0] pulse 6 edges after its start.
REQ-034 i=8'hFF held, reset_n pulsed low while cnt==2 -> o=0, pulses 0 asynchronously; after release o=8'hFF 6 edges after first sampling edge, one o_rise=8'hFF pulse.
REQ-035 STAGES=3, FILTER_CYCLES=0, RESET_VALUE=8'hFF, i=8'h0F from edge 1 -> o=8'h0F at edge 4; o_fall=8'hF0 one cycle.
